// File: rtl/puf_ctrl.sv
// -----------------------------------------------------------------------------
// puf_ctrl -- challenge/response controller for an arbiter PUF.
//
// Accepts a challenge, drives it onto the PUF select bus, then launches the race
// EVALS times. Each launch is SETTLE cycles of ce=0 followed by HOLD cycles of
// ce=1. The arbiter is sampled on the last HOLD cycle of every launch. The
// controller returns the majority vote, the ones count and an integrity flag.
//
// Optional build macro: PUF_CTRL_SYNC_EN
//   defined   : q/qn pass through two-flop synchronizers before sampling
//               (HOLD must be >= 3)
//   undefined : q/qn are sampled directly (HOLD >= 1)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   chal_valid/ready    challenge handshake (ready is high only in IDLE, out of reset)
//   chal_data[SEL_W]    challenge value
//   sel[SEL_W]          registered challenge to the PUF
//   ce                  registered launch enable to the PUF
//   q, qn               arbiter outputs
//   rsp_valid/ready     response handshake
//   rsp_bit             majority vote (ones > EVALS/2)
//   rsp_ones[CNT_W]     number of samples with q=1
//   rsp_err             at least one sample had q==qn
// -----------------------------------------------------------------------------
module puf_ctrl #(
    parameter int unsigned SEL_W  = 32,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned HOLD   = 4,
    parameter int unsigned EVALS  = 15,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chal_valid,
    output logic             chal_ready,
    input  logic [SEL_W-1:0] chal_data,
    output logic [SEL_W-1:0] sel,
    output logic             ce,
    input  logic             q,
    input  logic             qn,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_bit,
    output logic [CNT_W-1:0] rsp_ones,
    output logic             rsp_err
);

    localparam int unsigned PH_MAX = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned HALF   = EVALS / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_FIRE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Arbiter sample path (optionally synchronized)
    logic q_smp;
    logic qn_smp;

`ifdef PUF_CTRL_SYNC_EN
    localparam int unsigned MIN_HOLD = 3;

    logic [1:0] q_sync_q;
    logic [1:0] qn_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sync_q  <= 2'b00;
            qn_sync_q <= 2'b00;
        end else begin
            q_sync_q  <= {q_sync_q[0], q};
            qn_sync_q <= {qn_sync_q[0], qn};
        end
    end

    assign q_smp  = q_sync_q[1];
    assign qn_smp = qn_sync_q[1];
`else
    localparam int unsigned MIN_HOLD = 1;

    assign q_smp  = q;
    assign qn_smp = qn;
`endif

    // Elaboration-time parameter checks
    if ((EVALS % 2) != 1) begin : g_chk_evals
        $error("puf_ctrl: EVALS must be odd and >= 1");
    end
    if (SETTLE < 1) begin : g_chk_settle
        $error("puf_ctrl: SETTLE must be >= 1");
    end
    if (HOLD < MIN_HOLD) begin : g_chk_hold
        $error("puf_ctrl: HOLD too small for the selected sample path");
    end
    if ((CNT_W < 1) || ((64'd1 << CNT_W) <= 64'(EVALS))) begin : g_chk_cnt
        $error("puf_ctrl: CNT_W too small, need 2**CNT_W > EVALS");
    end

    state_t             state_q,    state_d;
    logic [PH_W-1:0]    ph_q,       ph_d;
    logic [CNT_W-1:0]   eval_q,     eval_d;
    logic [CNT_W-1:0]   ones_q,     ones_d;
    logic               err_q,      err_d;
    logic [SEL_W-1:0]   sel_q,      sel_d;
    logic               ce_q,       ce_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_bit_q,  rsp_bit_d;
    logic [CNT_W-1:0]   rsp_ones_q, rsp_ones_d;
    logic               rsp_err_q,  rsp_err_d;

    // Ready depends on rst directly so nothing is accepted while reset is held
    assign chal_ready = (state_q == S_IDLE) && !rst;

    assign sel       = sel_q;
    assign ce        = ce_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign rsp_ones  = rsp_ones_q;
    assign rsp_err   = rsp_err_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            eval_q      <= '0;
            ones_q      <= '0;
            err_q       <= 1'b0;
            sel_q       <= '0;
            ce_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_ones_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            eval_q      <= eval_d;
            ones_q      <= ones_d;
            err_q       <= err_d;
            sel_q       <= sel_d;
            ce_q        <= ce_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_ones_q  <= rsp_ones_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        eval_d     = eval_q;
        ones_d     = ones_q;
        err_d      = err_q;
        sel_d      = sel_q;
        rsp_bit_d  = rsp_bit_q;
        rsp_ones_d = rsp_ones_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (chal_valid && chal_ready) begin
                    sel_d   = chal_data;
                    ph_d    = '0;
                    eval_d  = '0;
                    ones_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_LOW;
                end
            end

            S_LOW: begin
                if (ph_q == PH_W'(SETTLE - 1)) begin
                    ph_d    = '0;
                    state_d = S_FIRE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            S_FIRE: begin
                if (ph_q == PH_W'(HOLD - 1)) begin
                    // Last HOLD cycle: take the arbiter sample
                    ph_d   = '0;
                    ones_d = ones_q + CNT_W'(q_smp);
                    err_d  = err_q | (q_smp == qn_smp);
                    eval_d = eval_q + CNT_W'(1);
                    if (eval_q == CNT_W'(EVALS - 1)) begin
                        state_d    = S_DONE;
                        rsp_bit_d  = (ones_d > CNT_W'(HALF));
                        rsp_ones_d = ones_d;
                        rsp_err_d  = err_d;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ce and rsp_valid are registered images of the next state
        ce_d        = (state_d == S_FIRE);
        rsp_valid_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_puf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_ctrl -- scoreboard bench for puf_ctrl.
//
// The driver issues challenges and plays an arbiter q/qn pattern per launch;
// the expected response is derived from the pattern (popcount, majority,
// any q==qn) and queued at acceptance. An independent monitor checks responses,
// latency, ce launch shape, sel stability and asynchronous reset behaviour.
// Honours PUF_CTRL_SYNC_EN for the late-change sampling case.
// -----------------------------------------------------------------------------
module tb_puf_ctrl;

    localparam int unsigned SEL_W  = 32;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned EVALS  = 15;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LAT    = EVALS * (SETTLE + HOLD);

    logic             clk = 1'b0;
    logic             rst;
    logic             chal_valid;
    logic             chal_ready;
    logic [SEL_W-1:0] chal_data;
    logic [SEL_W-1:0] sel;
    logic             ce;
    logic             q;
    logic             qn;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_bit;
    logic [CNT_W-1:0] rsp_ones;
    logic             rsp_err;

    puf_ctrl #(
        .SEL_W  (SEL_W),
        .SETTLE (SETTLE),
        .HOLD   (HOLD),
        .EVALS  (EVALS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chal_valid (chal_valid),
        .chal_ready (chal_ready),
        .chal_data  (chal_data),
        .sel        (sel),
        .ce         (ce),
        .q          (q),
        .qn         (qn),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_bit    (rsp_bit),
        .rsp_ones   (rsp_ones),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SEL_W-1:0] chal;
        logic             bit_e;
        logic [CNT_W-1:0] ones;
        logic             err;
        int               acc;
    } exp_t;

    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int stall_left = 0;

    function automatic void chk(input string nm, input longint act, input longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endfunction

    task automatic die(input string nm);
        $display("FAIL %s: bounded wait expired at cycle %0d", nm, cyc);
        $fatal(1, "bench aborted");
    endtask

    task automatic wait_ce(input logic lvl);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (ce == lvl) return;
        end
        die(lvl ? "ce_rise_wait" : "ce_fall_wait");
    endtask

    // Issue one challenge and play the q/qn pattern (index k = launch k).
    // late: q/qn flip one cycle before the sample point.
    // abort_at >= 0: assert reset during that launch; nothing is expected.
    task automatic issue(input logic [SEL_W-1:0] d, input logic [EVALS-1:0] pq,
                         input logic [EVALS-1:0] pqn, input bit late, input int abort_at);
        logic [EVALS-1:0] eq;
        logic [EVALS-1:0] eqn;
        exp_t             e;
        bit               got;
        int               ones;

        eq  = pq;
        eqn = pqn;
`ifndef PUF_CTRL_SYNC_EN
        if (late) begin
            eq  = ~pq;
            eqn = ~pqn;
        end
`endif
        ones    = $countones(eq);
        e.chal  = d;
        e.ones  = CNT_W'(ones);
        e.bit_e = (ones > int'(EVALS / 2));
        e.err   = |(eq ~^ eqn);

        chal_valid = 1'b1;
        chal_data  = d;
        got        = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (chal_ready) begin
                got   = 1'b1;
                e.acc = cyc + 1;
            end
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                rsp_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!got) die("accept_wait");
        chal_valid = 1'b0;
        chal_data  = $urandom;
        if (stall_left > 0) rsp_ready = 1'b0;
        if (abort_at < 0) sbq.push_back(e);

        for (int k = 0; k < int'(EVALS); k++) begin
            wait_ce(1'b1);
            q  = pq[k];
            qn = pqn[k];
            if (k == abort_at) begin
                #2;
                rst = 1'b1;
                q   = 1'b0;
                qn  = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (late) begin
                repeat (HOLD - 1) @(posedge clk);
                #1;
                q  = ~pq[k];
                qn = ~pqn[k];
            end
            wait_ce(1'b0);
            {q, qn} = 2'($urandom);
        end
    endtask

    // Monitor: launch shape, sel, responses, reset values
    logic ce_prev = 1'b0;
    logic v_prev  = 1'b0;
    int   run_lo  = 0;
    int   run_hi  = 0;
    int   launches = 0;
    exp_t m;

    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                chk("rst_ce", ce, 0);
                chk("rst_sel", sel, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_chal_ready", chal_ready, 0);
                chk("rst_rsp_fields", {rsp_bit, rsp_ones, rsp_err}, 0);
                ce_prev  = 1'b0;
                v_prev   = 1'b0;
                run_lo   = 0;
                run_hi   = 0;
                launches = 0;
            end else begin
                if (ce && !ce_prev) begin
                    launches++;
                    if (launches == 1) chk("settle_first", longint'(run_lo >= int'(SETTLE)), 1);
                    else               chk("settle_len", run_lo, SETTLE);
                    if (sbq.size() > 0) chk("sel_at_launch", sel, sbq[0].chal);
                    run_hi = 1;
                end else if (ce) begin
                    run_hi++;
                end else if (ce_prev) begin
                    chk("hold_len", run_hi, HOLD);
                    run_lo = 1;
                end else begin
                    run_lo++;
                end
                ce_prev = ce;

                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_valid_unexpected", rsp_valid, 0);
                    end else begin
                        m = sbq[0];
                        chk("rsp_ones", rsp_ones, m.ones);
                        chk("rsp_bit", rsp_bit, m.bit_e);
                        chk("rsp_err", rsp_err, m.err);
                        chk("done_ready_ce", {chal_ready, ce}, 0);
                        if (!v_prev) begin
                            chk("latency", cyc - m.acc, LAT);
                            chk("launch_count", launches, EVALS);
                        end
                        if (rsp_ready) begin
                            void'(sbq.pop_front());
                            launches = 0;
                        end
                    end
                end
                v_prev = rsp_valid;
            end
        end
    end

    // Stimulus
    initial begin
        logic [EVALS-1:0] pq;
        logic [EVALS-1:0] pqn;
        bit               idle;

        rst        = 1'b1;
        chal_valid = 1'b0;
        chal_data  = '0;
        q          = 1'b0;
        qn         = 1'b0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Constant q=1
        issue(32'hDEADBEEF, '1, '0, 1'b0, -1);
        // Seven ones then eight ones
        pq = 15'h007F;
        issue(32'h12345678, pq, ~pq, 1'b0, -1);
        pq = 15'h00FF;
        issue(32'h0BADF00D, pq, ~pq, 1'b0, -1);
        // q==qn on eval 5 only, then a clean challenge
        pq = 15'h0010;
        issue(32'hCAFE0005, pq, '1, 1'b0, -1);
        pq = 15'h5555;
        issue(32'hA5A5A5A5, pq, ~pq, 1'b0, -1);
        // Stall the response; the next challenge is held during DONE
        stall_left = 20;
        pq = 15'h3C3C;
        issue(32'h55AA55AA, pq, ~pq, 1'b0, -1);
        // Late q change one cycle before sampling
        pq = 15'h0F0F;
        issue(32'h0000FFFF, pq, ~pq, 1'b1, -1);
        // Reset during the third FIRE phase, then a fresh challenge
        pq = 15'h7FFF;
        issue(32'hFFFF0000, pq, ~pq, 1'b0, 2);
        pq = 15'h1248;
        issue(32'h87654321, pq, ~pq, 1'b0, -1);

        // Randomized challenges
        for (int n = 0; n < 20; n++) begin
            pq  = EVALS'($urandom);
            pqn = ~pq;
            if ($urandom_range(0, 3) == 0) pqn[$urandom_range(0, EVALS - 1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) stall_left = int'($urandom_range(1, 12));
            issue($urandom, pq, pqn, ($urandom_range(0, 3) == 0), -1);
        end

        // Drain
        idle = 1'b0;
        for (int i = 0; i < 1000 && !idle; i++) begin
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            if (chal_ready && sbq.size() == 0) idle = 1'b1;
        end
        if (!idle) die("drain_wait");
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_ctrl.md
Name: puf_ctrl

Overview:
Challenge/response controller that drives the arbiter PUF from the initiator side. It accepts a challenge over a valid/ready handshake and drives it onto the PUF `sel` bus. It then launches the race by toggling `ce` repeatedly, EVALS times, and samples the arbiter `Q`/`Qn` after each launch. It returns a majority-voted response bit, the ones count and an integrity flag over a second valid/ready handshake. It sits between the host/test logic and the puf instance.

Parameters:
- SEL_W, 32: challenge width; drives puf `sel`.
- SETTLE, 4: cycles `ce`=0 before each launch (race flops cleared, `sel` and mux path settled); must be >=1.
- HOLD, 4: cycles `ce`=1 per launch; the arbiter is sampled on the last HOLD cycle; must be >=1.
- EVALS, 15: evaluations per challenge; must be odd and >=1.
- CNT_W, 4: width of the ones counter; must satisfy 2**CNT_W > EVALS.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- chal_valid, in, 1: challenge offered.
- chal_ready, out, 1: controller idle and can accept.
- chal_data, in, SEL_W: challenge value.
- sel, out, SEL_W: registered challenge to puf.
- ce, out, 1: registered launch enable to puf.
- q, in, 1: arbiter output.
- qn, in, 1: arbiter complementary output.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer accepts response.
- rsp_bit, out, 1: majority vote.
- rsp_ones, out, CNT_W: number of samples with q=1.
- rsp_err, out, 1: at least one sample had q==qn.

Behaviour:
- Reset (async): state IDLE; sel=0, ce=0, rsp_valid=0, rsp_bit=0, rsp_ones=0, rsp_err=0; internal counters 0.
- While rst is high no challenge is accepted. chal_ready=1 exactly when state==IDLE and rst is low.
- States:
  - IDLE: ce=0. On chal_valid&&chal_ready: sel<=chal_data, clear ones/err/eval counters, go to LOW.
  - LOW: ce=0 for SETTLE cycles, then go to FIRE.
  - FIRE: ce=1 for HOLD cycles. On the last HOLD cycle, sample q/qn:
    - ones+=q;
    - err|=(q==qn);
    - eval+=1.
    - If eval==EVALS, go to DONE; else go to LOW.
  - DONE: ce=0; rsp_valid=1; rsp_bit=(ones > EVALS/2), integer division; rsp_ones=ones; rsp_err=err.
    - Outputs are held stable until rsp_valid&&rsp_ready, then go to IDLE at that edge.
    - rsp_valid deasserts the following cycle.
- Latency: challenge accepted at edge t0 → rsp_valid high after edge t0+EVALS*(SETTLE+HOLD). Default 120 cycles.
- sel is constant from acceptance until the next acceptance; it is never changed while ce=1.
- ce is a glitch-free register output. Every launch is preceded by >=SETTLE cycles of ce=0.
- Challenge offered while busy: ignored (chal_ready=0); the requester holds it.
- No same-cycle accept in DONE: the next challenge can be accepted at the earliest one cycle after the response handshake.
- Counter width: ones saturates at EVALS by construction; no wrap is possible with a legal CNT_W.
- Reset mid-operation: abort immediately to the reset values.
  - ce drops asynchronously.
  - The partial result is discarded and never presented.
- Illegal parameters (even EVALS, SETTLE/HOLD=0, CNT_W too small): elaboration-time error via generate check.

Optional Feature:
- Macro: PUF_CTRL_SYNC_EN.
- Defined: q and qn each pass through a two-flop synchronizer (reset to 0) before sampling.
  - The sample point moves to the last HOLD cycle but uses the synchronized value. HOLD must therefore be >=3; this is an elaboration error otherwise.
  - Latency is unchanged.
- Undefined: q/qn are sampled directly; HOLD>=1 is allowed.

Test Plan:
- Constant q=1, qn=0; challenge 32'hDEADBEEF → sel=32'hDEADBEEF before the first ce rise; rsp_valid at t0+120; rsp_bit=1, rsp_ones=15, rsp_err=0.
- q pattern 1 on evals 1-7, 0 on evals 8-15 (qn=~q) → rsp_ones=7, rsp_bit=0; then q=1 on 8 evals → rsp_ones=8, rsp_bit=1.
- q=qn=1 on eval 5 only, else q=0/qn=1 → rsp_err=1, rsp_ones=1, rsp_bit=0; next challenge starts with rsp_err cleared.
- Hold rsp_ready=0 for 20 cycles after rsp_valid → outputs stable, chal_ready=0, ce=0; a new chal_valid during DONE is not accepted until one cycle after the handshake.
- Assert rst during the 3rd FIRE phase → ce=0 and sel=0 immediately (before the next clk); rsp_valid never rises; after release chal_ready=1 and a fresh challenge completes normally.
- Count ce rising edges per challenge = 15, each preceded by exactly 4 low cycles and lasting 4 cycles; with PUF_CTRL_SYNC_EN, a q change 1 cycle before the sample point is not captured.
